// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM state codes,
// mux selects and the control word consumed by the datapath.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_WB_I     = 4'd11,
        S_JR       = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,  // PC + 4 straight from the ALU
        PCSRC_ALUOUT = 2'b01,  // branch target latched in ALUOut
        PCSRC_JUMP   = 2'b10,
        PCSRC_REG    = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        SRCB_REG   = 2'b00,
        SRCB_FOUR  = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_SHIFT = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [1:0] REGDST_RT    = 2'b00;
    localparam logic [1:0] REGDST_RD    = 2'b01;
    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        pc_src_t    pc_source;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    // Unsupported opcodes map to FETCH, which no legal instruction targets from DECODE.
    function automatic state_t decode_target(input logic [5:0] opcode, input logic [5:0] funct);
        state_t tgt;
        case (opcode)
            OP_RTYPE:     tgt = (funct == FN_JR) ? S_JR : S_EXEC_R;
            OP_LW, OP_SW: tgt = S_MEM_ADDR;
            OP_BEQ:       tgt = S_BRANCH;
            OP_J:         tgt = S_JUMP;
            OP_ADDI:      tgt = S_EXEC_I;
            default:      tgt = S_FETCH;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decode: maps the current FSM state to the raw control word.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        // NOTE: every field gets a default before the case so no state can infer a latch.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE:   ctrl.alu_src_b = SRCB_SHIFT;
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = MEMTOREG_MEM;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_WB_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = REGDST_RD;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_WB_I: ctrl.reg_write = 1'b1;
            S_JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_REG;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic, and the
// handshake/reset gating applied on top of the Moore control word.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter bit HAS_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [1:0] pc_source,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [3:0] state
);

    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   ready;
    logic   illegal;
    logic   fetch_ok;

    assign ready = HAS_HANDSHAKE ? mem_ready : 1'b1;

    // opcode/funct are only looked at in DECODE and MEM_ADDR.
    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_d = decode_target(opcode, funct);
                illegal = (state_d == S_FETCH);
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   state_d = ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            default:    state_d = S_FETCH;
        endcase
    end

    // NOTE: reset is sampled on the clock edge only, and state updates use <= so every
    // reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    mips_ctrl_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // The fetch only commits PC and IR once memory has delivered the word.
    assign fetch_ok = (state_q != S_FETCH) || ready;

    assign pc_write      = rst_n & ctrl.pc_write & fetch_ok;
    assign ir_write      = rst_n & ctrl.ir_write & fetch_ok;
    assign pc_write_cond = rst_n & ctrl.pc_write_cond;
    assign mem_read      = rst_n & ctrl.mem_read;
    assign mem_write     = rst_n & ctrl.mem_write;
    assign reg_write     = rst_n & ctrl.reg_write;
    assign illegal_op    = rst_n & illegal;
    assign i_or_d        = ctrl.i_or_d;
    assign alu_src_a     = ctrl.alu_src_a;
    assign pc_source     = ctrl.pc_source;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign state         = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: walks each instruction class cycle by cycle
// and checks the state and the full control word against a hand-written table.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       alu_src_a, reg_write, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    mips_mc_control #(.HAS_HANDSHAKE(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .alu_src_a     (alu_src_a),
        .reg_write     (reg_write),
        .illegal_op    (illegal_op),
        .pc_source     (pc_source),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Word layout: pcw pcwc iord mr mw irw asa rw ill | pcs asb aop rd m2r
    function automatic logic [18:0] exp_word(input int st, input logic rdy, input logic ill,
                                             input logic rst_act);
        logic pcw, pcwc, iord, mr, mw, irw, asa, rw;
        logic [1:0] pcs, asb, aop, rd, m2r;
        {pcw, pcwc, iord, mr, mw, irw, asa, rw} = '0;
        {pcs, asb, aop, rd, m2r} = '0;
        case (st)
            0:  begin mr = 1; pcw = rdy; irw = rdy; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 2'b01; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 2'b01; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            12: begin pcw = 1; pcs = 2'b11; end
            default: ;
        endcase
        if (rst_act) {pcw, pcwc, irw, mr, mw, rw} = '0;
        return {pcw, pcwc, iord, mr, mw, irw, asa, rw, ill && !rst_act,
                pcs, asb, aop, rd, m2r};
    endfunction

    // Checks one cycle at the falling edge, then steps to just after the next rising edge.
    task automatic cyc(input string tag, input int st, input logic ill = 1'b0);
        logic [18:0] obs, exp;
        @(negedge clk);
        n_cmp++;
        assert (state === 4'(st)) else begin
            n_bad++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, st);
        end
        obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, alu_src_a,
               reg_write, illegal_op, pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg};
        exp = exp_word(st, mem_ready, ill, !rst_n);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s ctrl: observed %b expected %b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        funct     = 6'b000000;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        cyc("reset", 0);
        rst_n = 1'b1;

        // lw with memory always ready
        opcode = 6'b100011;
        cyc("lw_f", 0); cyc("lw_d", 1); cyc("lw_a", 2); cyc("lw_r", 3); cyc("lw_wb", 4);

        // add
        opcode = 6'b000000; funct = 6'b100000;
        cyc("add_f", 0); cyc("add_d", 1); cyc("add_x", 6); cyc("add_wb", 7);

        // jr
        funct = 6'b001000;
        cyc("jr_f", 0); cyc("jr_d", 1); cyc("jr_x", 12);

        // sw with a three-cycle write stall
        opcode = 6'b101011; funct = 6'b000000;
        cyc("sw_f", 0); cyc("sw_d", 1); cyc("sw_a", 2);
        mem_ready = 1'b0;
        cyc("sw_w0", 5); cyc("sw_w1", 5); cyc("sw_w2", 5);
        mem_ready = 1'b1;
        cyc("sw_w3", 5);

        // fetch stall then illegal opcode
        opcode = 6'b111111;
        mem_ready = 1'b0;
        cyc("fst0", 0); cyc("fst1", 0);
        mem_ready = 1'b1;
        cyc("fst2", 0);
        cyc("ill_d", 1, 1'b1);

        // beq, then j
        opcode = 6'b000100;
        cyc("beq_f", 0); cyc("beq_d", 1); cyc("beq_x", 8);
        opcode = 6'b000010;
        cyc("j_f", 0); cyc("j_d", 1); cyc("j_x", 9);

        // addi; opcode wiggles outside DECODE/MEM_ADDR must not matter
        opcode = 6'b001000;
        cyc("addi_f", 0); cyc("addi_d", 1);
        opcode = 6'b100011;
        cyc("addi_x", 10); cyc("addi_wb", 11);

        // reset while stalled in MEM_RD
        cyc("lwr_f", 0); cyc("lwr_d", 1); cyc("lwr_a", 2);
        mem_ready = 1'b0;
        cyc("lwr_r", 3);
        rst_n = 1'b0;
        cyc("lwr_rst", 3);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        cyc("lwr_after", 0);

        // reset while stalled in MEM_WR
        opcode = 6'b101011;
        cyc("swr_d", 1); cyc("swr_a", 2);
        mem_ready = 1'b0;
        cyc("swr_w", 5);
        rst_n = 1'b0;
        cyc("swr_rst", 5);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        cyc("swr_after", 0);
        cyc("swr_next", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have parameter HAS_HANDSHAKE, default 1, meaning: when 0, mem_ready is ignored and treated as 1.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port opcode  input  6  instr[31:26] from the instruction register.
REQ-005 SHALL have port funct  input  6  instr[5:0] from the instruction register.
REQ-006 SHALL have port mem_ready  input  1  memory has completed the current read or write.
REQ-007 SHALL have 1-bit outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, alu_src_a, reg_write and illegal_op.
REQ-008 SHALL have 2-bit outputs pc_source, alu_src_b, alu_op, reg_dst and mem_to_reg; pc_source and alu_src_b each drive a mux4to1_32bit select.
REQ-009 SHALL have port state  output  4  current FSM state, for debug.

Function
REQ-010 SHALL be a Moore FSM; outputs decode from state only, except where REQ-013 and REQ-021 gate them.
REQ-011 SHALL use these states: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, WB_MEM=4, MEM_WR=5, EXEC_R=6, WB_R=7, BRANCH=8, JUMP=9, EXEC_I=10, WB_I=11, JR=12.
- Codes 13-15 are illegal and SHALL go to FETCH on the next edge.
REQ-012 SHALL drive every output not listed for a state to 0.
REQ-013 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
- pc_write=ir_write=mem_ready.
- Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
REQ-014 DECODE: alu_src_b=11, alu_op=00. Next state by opcode and funct:
- 000000 with funct 001000 -> JR; any other 000000 -> EXEC_R.
- 100011 or 101011 -> MEM_ADDR.
- 000100 -> BRANCH.
- 000010 -> JUMP.
- 001000 -> EXEC_I.
- anything else -> FETCH with illegal_op=1 for that cycle only.
REQ-015 MEM_ADDR: alu_src_a=1, alu_src_b=10. Next is MEM_RD if opcode=100011, else MEM_WR.
REQ-016 MEM_RD: mem_read=1, i_or_d=1. Holds while mem_ready=0, then goes to WB_MEM.
REQ-017 WB_MEM: reg_dst=00, mem_to_reg=01, reg_write=1, then FETCH.
REQ-018 MEM_WR: mem_write=1, i_or_d=1. Holds while mem_ready=0, then goes to FETCH.
REQ-019 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, then WB_R. WB_R: reg_dst=01, reg_write=1, then FETCH.
REQ-020 Remaining states:
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, then FETCH.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- JR: pc_write=1, pc_source=11, then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, then WB_I. WB_I: reg_dst=00, reg_write=1, then FETCH.
REQ-021 SHALL force pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write and illegal_op to 0 while rst_n=0.
REQ-022 SHALL sample opcode and funct only in DECODE and MEM_ADDR; changes on them in any other state SHALL have no effect.

Reset
REQ-023 SHALL load state with FETCH on any rising clk edge where rst_n=0, regardless of the current state; this includes a reset mid-MEM_WR, with mem_write dropping in the same cycle.
REQ-024 SHALL begin the first fetch on the first edge after rst_n returns to 1; there SHALL be no asynchronous path from rst_n to state.

Structure
REQ-025 Opcode/funct constants, state codes, and pc_source/alu_src_b/alu_op encodings SHALL live in shared package mips_ctrl_pkg for reuse by the datapath and ALU control.
REQ-026 Output decode SHALL be one combinational sub-module, mips_ctrl_outdec (state in, control word out); next-state logic and the state register stay in mips_mc_control.

Verification
REQ-027 lw (opcode 100011), mem_ready held at 1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=01 only in the 5th cycle.
REQ-028 R-type add (000000/100000) -> 0,1,6,7,0; jr (000000/001000) -> 0,1,12,0 with pc_source=11 and pc_write=1 in state 12.
REQ-029 sw with mem_ready=0 for 3 cycles in MEM_WR -> state 5 held 4 cycles with mem_write=1 throughout, then FETCH.
REQ-030 FETCH with mem_ready=0 for 2 cycles -> pc_write=ir_write=0 for 2 cycles, then 1 for one cycle; next state is DECODE.
REQ-031 Opcode 111111 in DECODE -> illegal_op=1 for exactly one cycle, next state FETCH; beq (000100) -> 0,1,8,0 with pc_write_cond=1 and pc_source=01 in state 8.
REQ-032 rst_n=0 for one edge while in MEM_RD -> state=FETCH next cycle; all write enables are 0 during the reset cycle.
